// File: rtl/bcd_down_timer.sv
// Multi-digit BCD countdown timer with programmable prescaler, pause/run control
// and a one-cycle expiry pulse for the game-control FSM.
module bcd_down_timer #(
  parameter int DIGITS   = 2,
  parameter int PRESCALE = 50000000,
  parameter int PS_W     = 26
) (
  input  logic                  clk,
  input  logic                  resetN,
  input  logic                  loadN,
  input  logic                  start,
  input  logic                  pause,
  input  logic                  enable,
  input  logic [4*DIGITS-1:0]   datain,
  output logic [4*DIGITS-1:0]   count,
  output logic                  tick,
  output logic                  running,
  output logic                  expired,
  output logic                  tc,
  output logic [1:0]            state_dbg
);

  localparam int CW = 4 * DIGITS;

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_RUN     = 2'd1;
  localparam logic [1:0] S_PAUSE   = 2'd2;
  localparam logic [1:0] S_EXPIRED = 2'd3;

  localparam logic [PS_W-1:0] PS_LAST = PS_W'(PRESCALE - 1);

  logic [1:0]      state, state_n;
  logic [PS_W-1:0] ps, ps_n;
  logic [CW-1:0]   count_n;
  logic            tick_n, exp_n, advance;

  // Out-of-range digits load as 9 so the display never shows a non-BCD glyph.
  function automatic logic [CW-1:0] bcd_clamp(input logic [CW-1:0] v);
    bcd_clamp = v;
    for (int i = 0; i < DIGITS; i++) begin
      if (v[4*i +: 4] > 4'd9) bcd_clamp[4*i +: 4] = 4'd9;
    end
  endfunction

  // Ripple-borrow decrement: a zero digit becomes 9 and borrows from the next.
  function automatic logic [CW-1:0] bcd_dec(input logic [CW-1:0] v);
    logic borrow;
    bcd_dec = v;
    borrow  = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      if (borrow) begin
        if (v[4*i +: 4] == 4'd0) begin
          bcd_dec[4*i +: 4] = 4'd9;
        end else begin
          bcd_dec[4*i +: 4] = v[4*i +: 4] - 4'd1;
          borrow = 1'b0;
        end
      end
    end
  endfunction

  always_comb begin
    state_n = state;
    ps_n    = ps;
    count_n = count;
    tick_n  = 1'b0;
    exp_n   = 1'b0;
    advance = 1'b0;
    if (!loadN) begin
      count_n = bcd_clamp(datain);
      ps_n    = '0;
      state_n = S_IDLE;
    end else begin
      case (state)
        S_IDLE, S_EXPIRED: begin
          if (start && !tc) begin
            state_n = S_RUN;
            ps_n    = '0;
          end
        end
        S_RUN: begin
          if (pause) state_n = S_PAUSE;
          else       advance = enable;
        end
        S_PAUSE: begin
          // The release cycle counts as a run cycle, so paused time is exactly
          // the cycles pause was high.
          if (!pause) begin
            state_n = S_RUN;
            advance = enable;
          end
        end
        default: state_n = S_IDLE;
      endcase
    end
    if (advance) begin
      if (ps == PS_LAST) begin
        ps_n    = '0;
        count_n = bcd_dec(count);
        tick_n  = 1'b1;
        if (count_n == '0) begin
          state_n = S_EXPIRED;
          exp_n   = 1'b1;
        end
      end else begin
        ps_n = ps + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state   <= S_IDLE;
      ps      <= '0;
      count   <= '0;
      tick    <= 1'b0;
      expired <= 1'b0;
    end else begin
      state   <= state_n;
      ps      <= ps_n;
      count   <= count_n;
      tick    <= tick_n;
      expired <= exp_n;
    end
  end

  assign tc        = (count == '0);
  assign running   = (state == S_RUN);
  assign state_dbg = state;

endmodule
